riscv_div: RTL and testbench

//  Iterative integer divider for the RV32M/RV64M DIV/DIVU/REM/REMU (+W) instructions; counterpart of the

---
 rtl/riscv_opcodes_pkg.sv | 22 ++
 rtl/riscv_div_iter.sv | 61 ++++++
 rtl/riscv_div.sv | 219 +++++++++++++++++++++
 tb/tb_riscv_div.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/riscv_opcodes_pkg.sv
// Shared RISC-V opcode definitions used by the EX-stage arithmetic units.
// Holds the instruction length, the misa-style XLEN mode codes and the
// {funct7, funct3, opcode} match keys for the M-extension divide family.
package riscv_opcodes_pkg;

  localparam int ILEN = 32;

  // XLEN mode codes as carried on st_xlen.
  localparam logic [1:0] RV32I = 2'b01;
  localparam logic [1:0] RV64I = 2'b10;

  // Match keys: {funct7[6:0], funct3[2:0], opcode[6:0]}.
  localparam logic [16:0] DIV   = 17'b0000001_100_0110011;
  localparam logic [16:0] DIVU  = 17'b0000001_101_0110011;
  localparam logic [16:0] REM   = 17'b0000001_110_0110011;
  localparam logic [16:0] REMU  = 17'b0000001_111_0110011;
  localparam logic [16:0] DIVW  = 17'b0000001_100_0111011;
  localparam logic [16:0] DIVUW = 17'b0000001_101_0111011;
  localparam logic [16:0] REMW  = 17'b0000001_110_0111011;
  localparam logic [16:0] REMUW = 17'b0000001_111_0111011;

endpackage

// File: rtl/riscv_div_iter.sv
// Radix-2 restoring shift-subtract datapath for riscv_div.
// Holds quotient, partial remainder and divisor; load_i presets all three,
// step_i performs one quotient-bit iteration.
// Ports:
//   clk, rstn   clock / async active-low reset
//   load_i      preset quo/rem/divisor from *_ld_i
//   step_i      execute one shift-subtract step
//   quo_ld_i    quotient register preset (dividend magnitude, or a preset result)
//   rem_ld_i    remainder register preset (zero, or a preset result)
//   dvs_ld_i    divisor magnitude
//   quo_o       quotient register
//   rem_o       remainder register (low XLEN bits)
module riscv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] quo_ld_i,
  input  logic [XLEN-1:0] rem_ld_i,
  input  logic [XLEN-1:0] dvs_ld_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN:0]   rem_q;   // one extra bit so the shifted remainder never overflows
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   rem_sh;
  logic            ge;

  always_comb begin
    rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      quo_q <= quo_ld_i;
      rem_q <= {1'b0, rem_ld_i};
      dvs_q <= dvs_ld_i;
    end else if (step_i) begin
      rem_q <= ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
      quo_q <= {quo_q[XLEN-2:0], ge};
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q[XLEN-1:0];

  // The top remainder bit is always clear after a step since rem < divisor.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[XLEN];

endmodule

// File: rtl/riscv_div.sv
// Iterative EX-stage divider for DIV/DIVU/REM/REMU (+W variants on RV64).
// Decodes id_instr, raises div_stall while the bit-serial loop runs, then
// presents the sign-corrected result on div_r with a one-cycle div_bubble=0.
// Ports:
//   clk, rstn    clock / async active-low reset
//   ex_stall     blocks acceptance of a new instruction only
//   div_stall    high while a division is in flight (registered)
//   id_bubble    id_instr is not valid
//   id_instr     instruction in EX
//   opA, opB     dividend (rs1), divisor (rs2)
//   st_xlen      current XLEN mode; RV32I disables W variants
//   div_bubble   low for one cycle when div_r is fresh
//   div_r        quotient or remainder, held until the next completion
module riscv_div
  import riscv_opcodes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_stall,
  output logic            div_stall,
  input  logic            id_bubble,
  input  logic [ILEN-1:0] id_instr,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [1:0]      st_xlen,
  output logic            div_bubble,
  output logic [XLEN-1:0] div_r
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {ST_IDLE, ST_DIVIDE, ST_FINISH} state_e;

  function automatic logic [XLEN-1:0] twos(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[XLEN-1]) ? twos(x) : x;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return XLEN'($signed(x[31:0]));
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negq_q, negq_d, negr_q, negr_d;
  logic            sel_rem_q, sel_rem_d, w_q, w_d;
  logic            div_stall_q, div_stall_d, div_bubble_q, div_bubble_d;
  logic [XLEN-1:0] div_r_q, div_r_d;

  logic [16:0]     key;
  logic            is_div, op_signed, op_rem, op_w, w_ok;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            sa, sb, b_zero, ovf, special, accept;
  logic            iter_load, iter_step;
  logic [XLEN-1:0] quo_ld, rem_ld, quo, rem, q_fix, r_fix, res;

  // ---------------- decode ----------------
  assign key  = {id_instr[31:25], id_instr[14:12], id_instr[6:0]};
  assign w_ok = (XLEN == 64) && (st_xlen != RV32I);

  always_comb begin
    // NOTE: every output gets a default first; a missing branch would otherwise infer a latch.
    is_div    = 1'b0;
    op_signed = 1'b0;
    op_rem    = 1'b0;
    op_w      = 1'b0;
    case (key)
      DIV:   begin is_div = 1'b1; op_signed = 1'b1; end
      DIVU:  begin is_div = 1'b1; end
      REM:   begin is_div = 1'b1; op_signed = 1'b1; op_rem = 1'b1; end
      REMU:  begin is_div = 1'b1; op_rem = 1'b1; end
      DIVW:  begin is_div = w_ok; op_w = 1'b1; op_signed = 1'b1; end
      DIVUW: begin is_div = w_ok; op_w = 1'b1; end
      REMW:  begin is_div = w_ok; op_w = 1'b1; op_signed = 1'b1; op_rem = 1'b1; end
      REMUW: begin is_div = w_ok; op_w = 1'b1; op_rem = 1'b1; end
      default: ;
    endcase
  end

  // ---------------- operand preparation ----------------
  always_comb begin
    a_ext   = op_w ? (op_signed ? sext32(opA) : XLEN'(opA[31:0])) : opA;
    b_ext   = op_w ? (op_signed ? sext32(opB) : XLEN'(opB[31:0])) : opB;
    sa      = op_signed & a_ext[XLEN-1];
    sb      = op_signed & b_ext[XLEN-1];
    a_mag   = abs_val(a_ext, op_signed);
    b_mag   = abs_val(b_ext, op_signed);
    b_zero  = (b_ext == '0);
    // Most-negative dividend: for W ops that is sext32(0x80000000).
    ovf     = op_signed && (b_ext == '1) &&
              (a_ext == (op_w ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}}));
    special = b_zero | ovf;
    accept  = (state_q == ST_IDLE) && !ex_stall && !id_bubble && is_div;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = special ? ST_FINISH : ST_DIVIDE;
      ST_DIVIDE: if (cnt_q == '0) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- result correction ----------------
  always_comb begin
    q_fix = negq_q ? twos(quo) : quo;
    r_fix = negr_q ? twos(rem) : rem;
    res   = sel_rem_q ? r_fix : q_fix;
    if (w_q) res = sext32(res);
  end

  // ---------------- FSM: outputs / datapath control ----------------
  always_comb begin
    iter_load    = 1'b0;
    iter_step    = 1'b0;
    quo_ld       = a_mag;
    rem_ld       = '0;
    cnt_d        = cnt_q;
    negq_d       = negq_q;
    negr_d       = negr_q;
    sel_rem_d    = sel_rem_q;
    w_d          = w_q;
    div_stall_d  = div_stall_q;
    div_bubble_d = 1'b1;
    div_r_d      = div_r_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        iter_load   = 1'b1;
        sel_rem_d   = op_rem;
        w_d         = op_w;
        div_stall_d = 1'b1;
        cnt_d       = op_w ? CW'(31) : CW'(XLEN - 1);
        if (b_zero) begin
          // Preset result: quotient all ones, remainder = dividend.
          quo_ld = '1;
          rem_ld = a_ext;
          negq_d = 1'b0;
          negr_d = 1'b0;
        end else if (ovf) begin
          quo_ld = a_ext;
          negq_d = 1'b0;
          negr_d = 1'b0;
        end else begin
          // W dividends are parked in the upper half so 32 steps consume them.
          quo_ld = op_w ? (a_mag << (XLEN - 32)) : a_mag;
          negq_d = sa ^ sb;
          negr_d = sa;
        end
      end
      ST_DIVIDE: begin
        iter_step = 1'b1;
        cnt_d     = cnt_q - CW'(1);
      end
      ST_FINISH: begin
        div_r_d      = res;
        div_bubble_d = 1'b0;
        div_stall_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
      sel_rem_q    <= 1'b0;
      w_q          <= 1'b0;
      div_stall_q  <= 1'b0;
      div_bubble_q <= 1'b1;
      div_r_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      negq_q       <= negq_d;
      negr_q       <= negr_d;
      sel_rem_q    <= sel_rem_d;
      w_q          <= w_d;
      div_stall_q  <= div_stall_d;
      div_bubble_q <= div_bubble_d;
      div_r_q      <= div_r_d;
    end
  end

  riscv_div_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rstn     (rstn),
    .load_i   (iter_load),
    .step_i   (iter_step),
    .quo_ld_i (quo_ld),
    .rem_ld_i (rem_ld),
    .dvs_ld_i (b_mag),
    .quo_o    (quo),
    .rem_o    (rem)
  );

  assign div_stall  = div_stall_q;
  assign div_bubble = div_bubble_q;
  assign div_r      = div_r_q;

  // Register and immediate fields are not needed to identify a divide.
  logic unused_instr;
  assign unused_instr = ^{id_instr[24:15], id_instr[11:7]};

endmodule

// File: tb/tb_riscv_div.sv
// Directed self-checking bench for riscv_div: a 32-bit instance for the
// main function and a 64-bit instance for the W variants.
module tb_riscv_div;
  import riscv_opcodes_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_stall;
  logic        bub32, bub64;
  logic [31:0] instr32, instr64;
  logic [31:0] opA32, opB32;
  logic [63:0] opA64, opB64;
  logic [1:0]  st_xlen;
  logic        stall32, stall64, bub_o32, bub_o64;
  logic [31:0] r32;
  logic [63:0] r64;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  riscv_div #(.XLEN(32)) dut32 (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .div_stall(stall32),
    .id_bubble(bub32), .id_instr(instr32), .opA(opA32), .opB(opB32),
    .st_xlen(st_xlen), .div_bubble(bub_o32), .div_r(r32)
  );

  riscv_div #(.XLEN(64)) dut64 (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .div_stall(stall64),
    .id_bubble(bub64), .id_instr(instr64), .opA(opA64), .opB(opB64),
    .st_xlen(st_xlen), .div_bubble(bub_o64), .div_r(r64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic w, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, (w ? 7'b0111011 : 7'b0110011)};
  endfunction

  // Issue one instruction and wait for its result pulse (bounded).
  task automatic run(input bit big, input logic [31:0] instr, input logic [63:0] a,
                     input logic [63:0] b, input bit tog,
                     output logic [63:0] res, output int lat, output int stall_cnt);
    @(negedge clk);
    if (big) begin instr64 = instr; opA64 = a; opB64 = b; bub64 = 1'b0; end
    else begin instr32 = instr; opA32 = a[31:0]; opB32 = b[31:0]; bub32 = 1'b0; end
    @(posedge clk); #1;
    bub32 = 1'b1;
    bub64 = 1'b1;
    lat = 0;
    stall_cnt = 0;
    while (lat < 200) begin
      if (big ? stall64 : stall32) stall_cnt++;
      if (tog) ex_stall = ~ex_stall;
      @(posedge clk); #1;
      lat++;
      if (!(big ? bub_o64 : bub_o32)) break;
    end
    ex_stall = 1'b0;
    res = big ? r64 : {32'b0, r32};
  endtask

  task automatic div_test(input string tag, input bit big, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input bit tog,
                          input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int lat, sc;
    run(big, enc(f3, w, 7'b0000001), a, b, tog, res, lat, sc);
    check({tag, "_res"}, res, exp);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_stallcyc"}, 64'(sc), 64'(exp_lat));
    check({tag, "_stall_low"}, {63'b0, big ? stall64 : stall32}, 64'd0);
  endtask

  initial begin
    rstn = 1'b0; ex_stall = 1'b0; bub32 = 1'b1; bub64 = 1'b1;
    instr32 = '0; instr64 = '0; opA32 = '0; opB32 = '0; opA64 = '0; opB64 = '0;
    st_xlen = RV64I;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_stall", {63'b0, stall32}, 64'd0);
    check("rst_bubble", {63'b0, bub_o32}, 64'd1);
    check("rst_r", {32'b0, r32}, 64'd0);
    check("rst_r64", r64, 64'd0);

    // Normal signed / unsigned divides: 32 steps + finish.
    div_test("div_20_m3", 0, 3'b100, 0, 64'd20, 64'hFFFF_FFFD, 0, 64'hFFFF_FFFA, 33);
    @(posedge clk); #1;
    check("pulse_once", {63'b0, bub_o32}, 64'd1);
    check("r_held", {32'b0, r32}, 64'hFFFF_FFFA);
    div_test("rem_20_m3", 0, 3'b110, 0, 64'd20, 64'hFFFF_FFFD, 0, 64'd2, 33);
    div_test("divu_max_2", 0, 3'b101, 0, 64'hFFFF_FFFF, 64'd2, 0, 64'h7FFF_FFFF, 33);
    div_test("remu_max_2", 0, 3'b111, 0, 64'hFFFF_FFFF, 64'd2, 0, 64'd1, 33);
    div_test("rem_m20_3", 0, 3'b110, 0, 64'hFFFF_FFEC, 64'd3, 0, 64'hFFFF_FFFE, 33);

    // Special cases complete one edge after acceptance.
    div_test("div_by0", 0, 3'b100, 0, 64'd7, 64'd0, 0, 64'hFFFF_FFFF, 1);
    div_test("rem_by0", 0, 3'b110, 0, 64'd7, 64'd0, 0, 64'd7, 1);
    div_test("div_ovf", 0, 3'b100, 0, 64'h8000_0000, 64'hFFFF_FFFF, 0, 64'h8000_0000, 1);
    div_test("rem_ovf", 0, 3'b110, 0, 64'h8000_0000, 64'hFFFF_FFFF, 0, 64'd0, 1);

    // ex_stall at issue blocks acceptance.
    @(negedge clk);
    ex_stall = 1'b1; instr32 = enc(3'b100, 0, 7'b0000001); opA32 = 32'd20; opB32 = 32'd3; bub32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("exstall_noaccept", {63'b0, stall32}, 64'd0);
    end
    @(negedge clk); bub32 = 1'b1; ex_stall = 1'b0;

    // ex_stall toggled mid-divide leaves latency unchanged.
    div_test("div_tog", 0, 3'b101, 0, 64'd100, 64'd7, 1, 64'd14, 33);

    // Bubbles and non-divide encodings never stall.
    @(negedge clk); instr32 = enc(3'b100, 0, 7'b0000001); bub32 = 1'b1;
    @(posedge clk); #1;
    check("bubble_div_nostall", {63'b0, stall32}, 64'd0);
    @(negedge clk); instr32 = enc(3'b000, 0, 7'b0000001); bub32 = 1'b0;
    @(posedge clk); #1;
    check("mul_nostall", {63'b0, stall32}, 64'd0);
    @(posedge clk); #1;
    check("mul_nopulse", {63'b0, bub_o32}, 64'd1);
    @(negedge clk); bub32 = 1'b1;

    // Reset in the middle of a division aborts it.
    @(negedge clk); instr32 = enc(3'b100, 0, 7'b0000001); opA32 = 32'd1000; opB32 = 32'd3; bub32 = 1'b0;
    @(posedge clk); #1; bub32 = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); rstn = 1'b0; #1;
    check("midrst_stall", {63'b0, stall32}, 64'd0);
    check("midrst_bubble", {63'b0, bub_o32}, 64'd1);
    check("midrst_r", {32'b0, r32}, 64'd0);
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("postrst_idle", {62'b0, stall32, bub_o32}, 64'd1);
    end
    div_test("div_after_rst", 0, 3'b100, 0, 64'd100, 64'd7, 0, 64'd14, 33);

    // 64-bit instance: full-width divide and W variants.
    div_test("div64", 1, 3'b100, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    div_test("divw_ovf", 1, 3'b100, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0,
             64'hFFFF_FFFF_8000_0000, 1);
    div_test("divw_m20_3", 1, 3'b100, 1, 64'h1234_5678_FFFF_FFEC, 64'd3, 0,
             64'hFFFF_FFFF_FFFF_FFFA, 33);
    div_test("remuw", 1, 3'b111, 1, 64'hABCD_0000_FFFF_FFFF, 64'd2, 0, 64'd1, 33);
    div_test("remw_by0", 1, 3'b110, 1, 64'h0000_0000_8000_0005, 64'h1_0000_0000, 0,
             64'hFFFF_FFFF_8000_0005, 1);

    // RV32I mode disables the W encodings.
    @(negedge clk);
    st_xlen = RV32I; instr64 = enc(3'b100, 1, 7'b0000001);
    opA64 = 64'h8000_0000; opB64 = '1; bub64 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rv32i_divw_idle", {62'b0, stall64, bub_o64}, 64'd1);
    end
    @(negedge clk); bub64 = 1'b1; st_xlen = RV64I;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
